// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: depth, pointer width,
// the NOP filler instruction and the {pc, inst} entry layout.
package fetch_buffer_pkg;

  localparam int FB_DEPTH = 8;
  localparam int PTR_W    = $clog2(FB_DEPTH);
  localparam int OCC_W    = PTR_W + 1;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fb_entry;

  localparam int ENTRY_W = $bits(fb_entry);

  // Number of valid words in a fill beat (0, 1 or 2).
  function automatic logic [1:0] popcount2(input logic [1:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]};
  endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch buffer: two write ports, two asynchronous read
// ports. Writes in the same cycle always target distinct addresses.
module fetch_buffer_mem
  import fetch_buffer_pkg::*;
(
  input  logic                   clk,
  input  logic                   we0,
  input  logic [PTR_W-1:0]       waddr0,
  input  logic [ENTRY_W-1:0]     wdata0,
  input  logic                   we1,
  input  logic [PTR_W-1:0]       waddr1,
  input  logic [ENTRY_W-1:0]     wdata1,
  input  logic [2*PTR_W-1:0]     raddr,
  output logic [2*ENTRY_W-1:0]   rdata
);

  logic [ENTRY_W-1:0] mem_reg [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem_reg[waddr0] <= wdata0;
    if (we1) mem_reg[waddr1] <= wdata1;
  end

  // Read port 0 serves the oldest entry, read port 1 the next one.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign rdata[gi*ENTRY_W +: ENTRY_W] = mem_reg[raddr[gi*PTR_W +: PTR_W]];
    end
  endgenerate

endmodule

// File: rtl/fetch_buffer.sv
// Eight-entry circular fetch buffer between instruction memory and a
// two-wide decoder. Pointers, occupancy and accept/pop control live here.
module fetch_buffer
  import fetch_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst0,
  input  logic [31:0] fetch_inst1,
  input  logic [1:0]  fetch_mask,
  output logic [31:0] instA,
  output logic [31:0] instB,
  output logic [31:0] pcA,
  output logic [31:0] pcB,
  output logic        validA,
  output logic        validB,
  input  logic        dec_ready,
  input  logic        flush,
  output logic [3:0]  occupancy
);

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [OCC_W-1:0] occ_reg, occ_next;

  logic             accept;
  logic             pop;
  logic [1:0]       push_cnt;
  logic [1:0]       pop_cnt;

  fb_entry          word0, word1;
  fb_entry          wr_entry0;
  logic             we0, we1;
  fb_entry          rd_entry [2];
  logic [2*PTR_W-1:0]   raddr;
  logic [2*ENTRY_W-1:0] rdata;

  // Readiness depends only on registered occupancy: room for a full 2-word beat.
  assign fetch_ready = (occ_reg <= OCC_W'(FB_DEPTH - 2));
  assign accept      = fetch_valid && fetch_ready && !flush;
  assign pop         = dec_ready && !flush;

  assign validA = (occ_reg >= OCC_W'(1));
  assign validB = (occ_reg >= OCC_W'(2));

  assign push_cnt = accept ? popcount2(fetch_mask) : 2'd0;
  assign pop_cnt  = pop ? ({1'b0, validA} + {1'b0, validB}) : 2'd0;

  assign word0 = '{pc: fetch_pc,          inst: fetch_inst0};
  assign word1 = '{pc: fetch_pc + 32'd4,  inst: fetch_inst1};

  // A lone word1 is packed into the tail slot so the buffer stays dense.
  assign wr_entry0 = fetch_mask[0] ? word0 : word1;
  assign we0       = rst_n && accept && (fetch_mask != 2'b00);
  assign we1       = rst_n && accept && (fetch_mask == 2'b11);

  assign head_next = head_reg + PTR_W'(pop_cnt);
  assign tail_next = tail_reg + PTR_W'(push_cnt);
  assign occ_next  = occ_reg + OCC_W'(push_cnt) - OCC_W'(pop_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      occ_reg  <= occ_next;
    end
  end

  assign raddr = {head_reg + PTR_W'(1), head_reg};

  fetch_buffer_mem u_mem (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (tail_reg),
    .wdata0 (wr_entry0),
    .we1    (we1),
    .waddr1 (tail_reg + PTR_W'(1)),
    .wdata1 (word1),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_entry[gi] = fb_entry'(rdata[gi*ENTRY_W +: ENTRY_W]);
    end
  endgenerate

  assign instA = validA ? rd_entry[0].inst : NOP_INST;
  assign pcA   = validA ? rd_entry[0].pc   : 32'h0;
  assign instB = validB ? rd_entry[1].inst : NOP_INST;
  assign pcB   = validB ? rd_entry[1].pc   : 32'h0;

  assign occupancy = occ_reg;

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-003 SHALL have port fetch_valid, input, 1, fill beat offered by instruction memory.
REQ-004 SHALL have port fetch_ready, output, 1, buffer accepts a fill beat this cycle.
REQ-005 SHALL have port fetch_pc, input, 32, PC of word0 (4-byte aligned); word1 PC = fetch_pc+4.
REQ-006 SHALL have port fetch_inst0 / fetch_inst1, input, 32 each, instruction words.
REQ-007 SHALL have port fetch_mask, input, 2, bit0 = word0 valid, bit1 = word1 valid.
REQ-008 SHALL have ports instA, instB, pcA, pcB, output, 32 each, oldest and second-oldest entries toward the decoder.
REQ-009 SHALL have ports validA, validB, output, 1 each, instA/instB meaningful.
REQ-010 SHALL have port dec_ready, input, 1, decoder consumes all presented valid slots this cycle.
REQ-011 SHALL have port flush, input, 1, redirect/flush; discards all buffered state.
REQ-012 SHALL have port occupancy, output, 4, current entry count 0..8.

Function
REQ-013 SHALL hold FB_DEPTH = 8 entries of {pc[31:0], inst[31:0]}, circular, 3-bit head/tail pointers wrapping mod 8.
REQ-014 fetch_ready SHALL be 1 iff occupancy <= 6, from current state only, with no combinational path from dec_ready or flush.
REQ-015 Accept = fetch_valid && fetch_ready && !flush; on accept, write popcount(fetch_mask) entries in order word0 then word1; mask 2'b10 writes only {fetch_pc+4, fetch_inst1}; mask 2'b00 writes nothing.
REQ-016 validA SHALL be (occupancy >= 1), validB SHALL be (occupancy >= 2); outputs driven combinationally from storage at head and head+1.
REQ-017 When a slot is invalid, its inst output SHALL be 32'h0000_0013 (NOP) and its pc output 32'h0.
REQ-018 Pop = dec_ready && !flush; removes validA+validB entries (0, 1 or 2) and advances head accordingly.
REQ-019 Push and pop in the same cycle SHALL both take effect; occupancy_next = occupancy + pushed - popped.
REQ-020 Latency: an entry written in cycle N SHALL be visible on instA/instB from cycle N+1; no bypass from fetch to decoder.
REQ-021 flush SHALL take priority: next cycle head = tail = 0, occupancy = 0; the same-cycle fill beat and pop SHALL be ignored.
REQ-022 Program order SHALL be preserved across wrap-around; pcA < pcB is not checked, because entries may come from separate redirects.
REQ-023 The design SHALL never write beyond capacity; fetch_valid while fetch_ready = 0 SHALL leave state unchanged.

Reset
REQ-024 While rst_n = 0 at a clock edge: head = tail = 0, occupancy = 0, validA = validB = 0, instA = instB = NOP, pcA = pcB = 0, fetch_ready = 1.
REQ-025 Reset mid-operation SHALL discard all entries exactly as flush does; storage contents need no reset.

Structure
REQ-026 A shared core package SHALL hold FB_DEPTH, the NOP_INST constant (32'h0000_0013) and the fb_entry typedef {pc, inst}.
REQ-027 Storage SHALL be a sub-module fetch_buffer_mem with 2 write ports and 2 read ports; pointer, occupancy and control logic stay in fetch_buffer.

Verification
REQ-028 Reset, then 1 beat (pc=0x100, mask=11, inst0=0xA, inst1=0xB) -> next cycle validA=validB=1, pcA=0x100, pcB=0x104, occupancy=2.
REQ-029 Beat with mask=10 at pc=0x200 into an empty buffer -> validA=1, pcA=0x204, instA=inst1, validB=0, instB=NOP.
REQ-030 Four 2-word beats with dec_ready=0 -> occupancy=8, fetch_ready=0; a fifth beat is ignored; one dec_ready pulse -> occupancy=6, fetch_ready=1.
REQ-031 Steady push of 2 and pop of 2 per cycle for 20 cycles -> occupancy constant, PCs continuous across pointer wrap, no drop or duplication.
REQ-032 flush in the same cycle as an accepted beat and dec_ready at occupancy=5 -> next cycle occupancy=0, validA=0, and the beat is not stored.
REQ-033 Occupancy=1 with dec_ready=1 and a 2-word beat in the same cycle -> pops 1, pushes 2, next occupancy=2, with head pointing to the new word0.
